// File: rtl/uart_sched_pkg.sv
// Shared types and widths for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int TIMER_W = 16;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        START,
        ACK,
        DONE,
        GAP
    } state_e;

endpackage

// File: rtl/sched_timer.sv
// Clear/count/compare timer shared by the ACK timeout and the inter-byte gap.
module sched_timer
    import uart_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic [TIMER_W-1:0] limit_i,
    output logic               hit_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;
    logic [TIMER_W-1:0] count_inc;

    assign count_inc = count_q + TIMER_W'(1);

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_inc;
        if (clr_i) begin
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires on the edge that completes the limit_i-th counted clock.
    assign hit_o = (count_inc == limit_i);

endmodule

// File: rtl/uart_tx_sched.sv
// Drains the byte FIFO into the UART transmitter: one read, one start pulse,
// busy handshake, optional gap; also flush sequencing, ack timeout and byte count.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter logic [TIMER_W-1:0] GAP_CYCLES  = 16'd0,
    parameter logic [TIMER_W-1:0] ACK_TIMEOUT = 16'd64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             flush_i,
    input  logic             fifo_empty_i,
    input  logic [7:0]       fifo_data_i,
    output logic             fifo_n_re_o,
    output logic             fifo_n_clr_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_start_o,
    input  logic             tx_busy_i,
    output logic             busy_o,
    output logic             err_o,
    output logic [CNT_W-1:0] bytes_sent_o
);

    state_e             state_q;
    logic               n_re_q;
    logic               n_clr_q;
    logic [7:0]         tx_data_q;
    logic               tx_start_q;
    logic               busy_q;
    logic               err_q;
    logic [CNT_W-1:0]   bytes_sent_q;

    logic               tmr_clr;
    logic               tmr_hit;
    logic [TIMER_W-1:0] tmr_limit;

    // ACK and GAP are never adjacent, so holding the timer clear in every other
    // state guarantees it starts from zero on entry to either.
    assign tmr_clr   = (state_q != ACK) && (state_q != GAP);
    assign tmr_limit = (state_q == ACK) ? ACK_TIMEOUT : GAP_CYCLES;

    sched_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (tmr_clr),
        .limit_i (tmr_limit),
        .hit_o   (tmr_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            n_re_q       <= 1'b1;
            n_clr_q      <= 1'b1;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            bytes_sent_q <= '0;
        end else begin
            n_re_q     <= 1'b1;
            tx_start_q <= 1'b0;
            n_clr_q    <= ~flush_i;
            if (flush_i) begin
                err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (enable_i && !fifo_empty_i && !flush_i) begin
                        state_q <= RD;
                        n_re_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RD: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= CAP;
                    end
                end
                CAP: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= START;
                        tx_data_q  <= fifo_data_i;
                        tx_start_q <= 1'b1;
                    end
                end
                START: begin
                    state_q <= ACK;
                end
                ACK: begin
                    if (tx_busy_i) begin
                        state_q      <= DONE;
                        bytes_sent_q <= bytes_sent_q + CNT_W'(1);
                    end else if (tmr_hit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (!tx_busy_i) begin
                        if (GAP_CYCLES == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (tmr_hit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_n_re_o  = n_re_q;
    assign fifo_n_clr_o = n_clr_q;
    assign tx_data_o    = tx_data_q;
    assign tx_start_o   = tx_start_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
    assign bytes_sent_o = bytes_sent_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a lagging-FIFO model, a busy-handshake
// transmitter model and a byte scoreboard checked on every start pulse.
module tb_uart_tx_sched;

    logic        clk;
    logic        rst;
    logic        enable_i;
    logic        flush_i;
    logic        fifo_empty_i;
    logic [7:0]  fifo_data_i;
    logic        fifo_n_re_o;
    logic        fifo_n_clr_o;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic        tx_busy_i;
    logic        busy_o;
    logic        err_o;
    logic [15:0] bytes_sent_o;

    uart_tx_sched #(
        .GAP_CYCLES  (16'd4),
        .ACK_TIMEOUT (16'd64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .flush_i      (flush_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_data_i  (fifo_data_i),
        .fifo_n_re_o  (fifo_n_re_o),
        .fifo_n_clr_o (fifo_n_clr_o),
        .tx_data_o    (tx_data_o),
        .tx_start_o   (tx_start_o),
        .tx_busy_i    (tx_busy_i),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .bytes_sent_o (bytes_sent_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // FIFO / transmitter models and scoreboard, evaluated mid-cycle.
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    bit  pend_re = 1'b0, pend_clr = 1'b0, empty_calc = 1'b1, re_prev = 1'b0;
    bit  start_pend = 1'b0, ack_en = 1'b1;
    int  cyc = 0, reads = 0, starts = 0, clr_lows = 0, empty_reads = 0, long_re = 0;
    int  last_read_cyc = 0, last_start_cyc = 0, last_fall_cyc = 0;
    int  busy_len = 10, busy_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        fifo_empty_i = empty_calc;
        if (pend_clr) begin
            fifo_q.delete();
        end else if (pend_re) begin
            if (fifo_q.size() == 0) empty_reads++;
            else fifo_data_i = fifo_q.pop_front();
        end
        empty_calc = (fifo_q.size() == 0);
        pend_re    = !fifo_n_re_o;
        pend_clr   = !fifo_n_clr_o;
        if (!fifo_n_re_o) begin
            reads++;
            last_read_cyc = cyc;
            if (re_prev) long_re++;
        end
        re_prev = !fifo_n_re_o;
        if (!fifo_n_clr_o) clr_lows++;

        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_busy_i     = 1'b0;
                last_fall_cyc = cyc;
            end
        end
        if (start_pend && ack_en) begin
            tx_busy_i = 1'b1;
            busy_cnt  = busy_len;
        end
        start_pend = tx_start_o;
        if (tx_start_o) begin
            starts++;
            last_start_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_start", 32'(tx_data_o), 32'hFFFF_FFFF);
            else check("tx_data", 32'(tx_data_o), 32'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_start(input string tag, input int max_cyc);
        int s0;
        s0 = starts;
        for (int i = 0; i < max_cyc; i++) begin
            tick(1);
            if (starts != s0) break;
        end
        check(tag, 32'(starts - s0), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_n_re"},  32'(fifo_n_re_o),  32'd1);
        check({tag, "_n_clr"}, 32'(fifo_n_clr_o), 32'd1);
        check({tag, "_data"},  32'(tx_data_o),    32'd0);
        check({tag, "_start"}, 32'(tx_start_o),   32'd0);
        check({tag, "_busy"},  32'(busy_o),       32'd0);
        check({tag, "_err"},   32'(err_o),        32'd0);
        check({tag, "_count"}, 32'(bytes_sent_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, s0, c0, s_cyc, err_cyc;
        bit got_err;
        rst          = 1'b0;
        enable_i     = 1'b0;
        flush_i      = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_data_i  = 8'h00;
        tx_busy_i    = 1'b0;
        tick(3);
        check_reset_values("reset");
        rst = 1'b1;
        tick(2);

        // Single byte: one read, start two cycles later, count 1, back to idle.
        busy_len = 10;
        r0 = reads;
        fifo_q.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        enable_i = 1'b1;
        wait_start("single_start", 50);
        check("single_read_to_start", 32'(last_start_cyc - last_read_cyc), 32'd2);
        tick(30);
        check("single_reads", 32'(reads - r0), 32'd1);
        check("single_count", 32'(bytes_sent_o), 32'd1);
        check("single_idle", 32'(busy_o), 32'd0);

        // Burst of three with a 4-clock gap after each busy fall.
        busy_len = 3;
        r0 = reads;
        for (int i = 1; i <= 3; i++) begin
            fifo_q.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            wait_start("burst_start", 60);
            if (i > 0) check("burst_gap_ge4", 32'(last_start_cyc - last_fall_cyc >= 4), 32'd1);
        end
        tick(40);
        check("burst_reads", 32'(reads - r0), 32'd3);
        check("burst_count", 32'(bytes_sent_o), 32'd4);

        // Ack timeout: error 64 clocks after ACK entry, count held, next byte still sent.
        ack_en = 1'b0;
        fifo_q.push_back(8'hB1);
        fifo_q.push_back(8'hB2);
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'hB2);
        wait_start("timeout_start", 50);
        s_cyc   = last_start_cyc;
        got_err = 1'b0;
        err_cyc = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (err_o === 1'b1) begin
                got_err = 1'b1;
                err_cyc = cyc;
                break;
            end
        end
        check("timeout_err_seen", 32'(got_err), 32'd1);
        check("timeout_latency", 32'(err_cyc - s_cyc), 32'd65);
        check("timeout_count", 32'(bytes_sent_o), 32'd4);
        ack_en = 1'b1;
        wait_start("timeout_next_start", 50);
        tick(30);
        check("timeout_next_count", 32'(bytes_sent_o), 32'd5);
        check("timeout_err_sticky", 32'(err_o), 32'd1);

        // Flush while in CAP: byte abandoned, one clear cycle, error cleared.
        s0 = starts;
        c0 = clr_lows;
        fifo_q.push_back(8'h3C);
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (fifo_n_re_o === 1'b0) break;
        end
        tick(1);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        tick(20);
        check("flush_no_start", 32'(starts - s0), 32'd0);
        check("flush_clr_cycles", 32'(clr_lows - c0), 32'd1);
        check("flush_idle", 32'(busy_o), 32'd0);
        check("flush_err_clear", 32'(err_o), 32'd0);
        check("flush_count", 32'(bytes_sent_o), 32'd5);

        // Disable during ACK with two bytes still queued.
        busy_len = 10;
        r0 = reads;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        exp_q.push_back(8'h11);
        wait_start("disable_start", 50);
        tick(1);
        enable_i = 1'b0;
        tick(40);
        check("disable_reads", 32'(reads - r0), 32'd1);
        check("disable_count", 32'(bytes_sent_o), 32'd6);
        check("disable_idle", 32'(busy_o), 32'd0);

        // Asynchronous reset while in ACK.
        exp_q.push_back(8'h22);
        enable_i = 1'b1;
        wait_start("reset_mid_start", 50);
        tick(1);
        rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        enable_i = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        tick(5);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("no_empty_reads", 32'(empty_reads), 32'd0);
        check("read_strobe_single", 32'(long_re), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
